// File: rtl/bp_be_ctx_switch_ctrl.sv
// Hardware-thread context switch sequencer and context-storage write-port arbiter.
// The switch, NPC bootstrap and rpush requests each sit in a one-entry holding buffer until served.
//
// state | meaning
// IDLE  | no switch in progress; write port serves npc/rpush buffers
// DRAIN | switch pending; wait for backend idle and no outstanding NPC write
// SAVE  | write resume NPC of the current thread into context storage
// LOAD  | read target thread's NPC from context storage
// REDIR | flush and redirect fetch to target NPC; current thread changes on exit
module bp_be_ctx_switch_ctrl #(
  parameter int threads_p        = 4,
  parameter int vaddr_width_p    = 39,
  parameter int dpath_width_p    = 64,
  parameter int reg_addr_width_p = 5,
  localparam int tid_w = (threads_p > 1) ? $clog2(threads_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        ctxt_v_i,
  input  logic [tid_w-1:0]            ctxt_tid_i,
  input  logic                        npc_v_i,
  input  logic [tid_w-1:0]            npc_tid_i,
  input  logic [vaddr_width_p-1:0]    npc_i,
  input  logic                        rpush_v_i,
  input  logic [tid_w-1:0]            rpush_tid_i,
  input  logic [reg_addr_width_p-1:0] rpush_reg_i,
  input  logic [dpath_width_p-1:0]    rpush_data_i,
  input  logic                        pipe_idle_i,
  input  logic [vaddr_width_p-1:0]    resume_npc_i,
  input  logic [vaddr_width_p-1:0]    ctx_r_npc_i,
  output logic                        busy_o,
  output logic                        stall_o,
  output logic                        ctx_w_v_o,
  output logic                        ctx_w_kind_o,
  output logic [tid_w-1:0]            ctx_w_tid_o,
  output logic [reg_addr_width_p-1:0] ctx_w_addr_o,
  output logic [dpath_width_p-1:0]    ctx_w_data_o,
  output logic                        ctx_r_v_o,
  output logic [tid_w-1:0]            ctx_r_tid_o,
  output logic                        redirect_v_o,
  output logic [vaddr_width_p-1:0]    redirect_npc_o,
  output logic [tid_w-1:0]            current_tid_o,
  output logic                        err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_SAVE  = 3'd2,
    S_LOAD  = 3'd3,
    S_REDIR = 3'd4
  } state_e;

  state_e state_r, state_n;

  logic                        sw_v_r;
  logic [tid_w-1:0]            sw_tid_r;
  logic                        npc_v_r;
  logic [tid_w-1:0]            npc_tid_r;
  logic [vaddr_width_p-1:0]    npc_r;
  logic                        rp_v_r;
  logic [tid_w-1:0]            rp_tid_r;
  logic [reg_addr_width_p-1:0] rp_reg_r;
  logic [dpath_width_p-1:0]    rp_data_r;
  logic [tid_w-1:0]            cur_tid_r;
  logic                        err_r;

  // Widened compare so the range check stays meaningful when threads_p is not a power of two.
  function automatic logic tid_in_range(input logic [tid_w-1:0] tid);
    return 32'(tid) < 32'(threads_p);
  endfunction

  logic ctxt_ok, npc_ok, rp_ok;
  logic sw_load, npc_load, rp_load, err_set;
  logic save_w, npc_gnt, sw_self, switch_done, switch_start;

  always_comb begin
    ctxt_ok      = tid_in_range(ctxt_tid_i);
    npc_ok       = tid_in_range(npc_tid_i) && (npc_tid_i != cur_tid_r);
    rp_ok        = tid_in_range(rpush_tid_i) && (rpush_tid_i != cur_tid_r);
    sw_load      = ctxt_v_i && ctxt_ok && !sw_v_r;
    npc_load     = npc_v_i && npc_ok && !npc_v_r;
    rp_load      = rpush_v_i && rp_ok && !rp_v_r;
    err_set      = (ctxt_v_i && (!ctxt_ok || sw_v_r))
                 || (npc_v_i && (!npc_ok || npc_v_r))
                 || (rpush_v_i && (!rp_ok || rp_v_r));
    save_w       = (state_r == S_SAVE);
    npc_gnt      = npc_v_r && !save_w;
    sw_self      = (state_r == S_IDLE) && sw_v_r && (sw_tid_r == cur_tid_r);
    switch_done  = (state_r == S_REDIR);
    // A fresh pulse starts the switch directly so DRAIN is entered the cycle after the CSR write.
    switch_start = (sw_v_r && (sw_tid_r != cur_tid_r))
                 || (sw_load && (ctxt_tid_i != cur_tid_r));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sw_v_r    <= 1'b0;
      sw_tid_r  <= '0;
      npc_v_r   <= 1'b0;
      npc_tid_r <= '0;
      npc_r     <= '0;
      rp_v_r    <= 1'b0;
      rp_tid_r  <= '0;
      rp_reg_r  <= '0;
      rp_data_r <= '0;
      cur_tid_r <= '0;
      err_r     <= 1'b0;
    end else begin
      if (sw_load) begin
        sw_v_r   <= 1'b1;
        sw_tid_r <= ctxt_tid_i;
      end else if (sw_self || switch_done) begin
        sw_v_r <= 1'b0;
      end

      if (npc_load) begin
        npc_v_r   <= 1'b1;
        npc_tid_r <= npc_tid_i;
        npc_r     <= npc_i;
      end else if (npc_gnt) begin
        npc_v_r <= 1'b0;
      end

      if (rp_load) begin
        rp_v_r    <= 1'b1;
        rp_tid_r  <= rpush_tid_i;
        rp_reg_r  <= rpush_reg_i;
        rp_data_r <= rpush_data_i;
      end else if (rp_v_r && !save_w && !npc_v_r) begin
        rp_v_r <= 1'b0;
      end

      if (switch_done) cur_tid_r <= sw_tid_r;
      if (err_set)     err_r     <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= S_IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:  if (switch_start) state_n = S_DRAIN;
      S_DRAIN: if (pipe_idle_i && !npc_v_r) state_n = S_SAVE;
      S_SAVE:  state_n = S_LOAD;
      S_LOAD:  state_n = S_REDIR;
      S_REDIR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = sw_v_r || npc_v_r || rp_v_r || (state_r != S_IDLE);
    stall_o        = (state_r != S_IDLE);
    ctx_w_v_o      = 1'b0;
    ctx_w_kind_o   = 1'b0;
    ctx_w_tid_o    = '0;
    ctx_w_addr_o   = '0;
    ctx_w_data_o   = '0;
    ctx_r_v_o      = 1'b0;
    ctx_r_tid_o    = '0;
    redirect_v_o   = 1'b0;
    redirect_npc_o = '0;
    current_tid_o  = cur_tid_r;
    err_o          = err_r;

    // Single write port: save beats npc bootstrap beats rpush.
    if (save_w) begin
      ctx_w_v_o    = 1'b1;
      ctx_w_tid_o  = cur_tid_r;
      ctx_w_data_o = dpath_width_p'(resume_npc_i);
    end else if (npc_v_r) begin
      ctx_w_v_o    = 1'b1;
      ctx_w_tid_o  = npc_tid_r;
      ctx_w_data_o = dpath_width_p'(npc_r);
    end else if (rp_v_r) begin
      ctx_w_v_o    = 1'b1;
      ctx_w_kind_o = 1'b1;
      ctx_w_tid_o  = rp_tid_r;
      ctx_w_addr_o = rp_reg_r;
      ctx_w_data_o = rp_data_r;
    end

    if (state_r == S_LOAD) begin
      ctx_r_v_o   = 1'b1;
      ctx_r_tid_o = sw_tid_r;
    end

    if (state_r == S_REDIR) begin
      redirect_v_o   = 1'b1;
      redirect_npc_o = ctx_r_npc_i;
    end
  end

endmodule

// File: tb/tb_bp_be_ctx_switch_ctrl.sv
// Bench for bp_be_ctx_switch_ctrl: table of npc/rpush vectors plus hand-written switch sequences,
// with storage writes, reads and redirects matched against scoreboard queues.
module tb_bp_be_ctx_switch_ctrl;
  localparam int TH = 4;
  localparam int VA = 39;
  localparam int DP = 64;
  localparam int RA = 5;

  logic          clk_i;
  logic          reset_n_i;
  logic          ctxt_v_i;
  logic [1:0]    ctxt_tid_i;
  logic          npc_v_i;
  logic [1:0]    npc_tid_i;
  logic [VA-1:0] npc_i;
  logic          rpush_v_i;
  logic [1:0]    rpush_tid_i;
  logic [RA-1:0] rpush_reg_i;
  logic [DP-1:0] rpush_data_i;
  logic          pipe_idle_i;
  logic [VA-1:0] resume_npc_i;
  logic [VA-1:0] ctx_r_npc_i;
  logic          busy_o, stall_o, ctx_w_v_o, ctx_w_kind_o;
  logic [1:0]    ctx_w_tid_o;
  logic [RA-1:0] ctx_w_addr_o;
  logic [DP-1:0] ctx_w_data_o;
  logic          ctx_r_v_o;
  logic [1:0]    ctx_r_tid_o;
  logic          redirect_v_o;
  logic [VA-1:0] redirect_npc_o;
  logic [1:0]    current_tid_o;
  logic          err_o;

  bp_be_ctx_switch_ctrl #(
    .threads_p(TH), .vaddr_width_p(VA), .dpath_width_p(DP), .reg_addr_width_p(RA)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .ctxt_v_i(ctxt_v_i), .ctxt_tid_i(ctxt_tid_i),
    .npc_v_i(npc_v_i), .npc_tid_i(npc_tid_i), .npc_i(npc_i),
    .rpush_v_i(rpush_v_i), .rpush_tid_i(rpush_tid_i), .rpush_reg_i(rpush_reg_i),
    .rpush_data_i(rpush_data_i),
    .pipe_idle_i(pipe_idle_i), .resume_npc_i(resume_npc_i), .ctx_r_npc_i(ctx_r_npc_i),
    .busy_o(busy_o), .stall_o(stall_o),
    .ctx_w_v_o(ctx_w_v_o), .ctx_w_kind_o(ctx_w_kind_o), .ctx_w_tid_o(ctx_w_tid_o),
    .ctx_w_addr_o(ctx_w_addr_o), .ctx_w_data_o(ctx_w_data_o),
    .ctx_r_v_o(ctx_r_v_o), .ctx_r_tid_o(ctx_r_tid_o),
    .redirect_v_o(redirect_v_o), .redirect_npc_o(redirect_npc_o),
    .current_tid_o(current_tid_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          kind;
    logic [1:0]    tid;
    logic [RA-1:0] addr;
    logic [DP-1:0] data;
  } wr_t;

  typedef struct {
    string         nm;
    logic          npc_v;
    logic [1:0]    npc_tid;
    logic [VA-1:0] npc;
    logic          rp_v;
    logic [1:0]    rp_tid;
    logic [RA-1:0] rp_reg;
    logic [DP-1:0] rp_data;
    int            nw;
    wr_t           w0;
    wr_t           w1;
    logic          exp_err;
  } vec_t;

  wr_t           wq[$];
  logic [1:0]    rq[$];
  logic [VA-1:0] dq[$];
  vec_t          vecs[6];
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic wr_t mkw(logic k, logic [1:0] t, logic [RA-1:0] a, logic [DP-1:0] d);
    return {k, t, a, d};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_pulses();
    ctxt_v_i  = 1'b0;
    npc_v_i   = 1'b0;
    rpush_v_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    clear_pulses();
    repeat (2) tick();
    reset_n_i = 1'b1;
  endtask

  // Scoreboard: every strobe must match the head of its queue.
  always @(negedge clk_i) begin : mon
    wr_t e;
    if (reset_n_i) begin
      if (ctx_w_v_o) begin
        if (wq.size() == 0) chk("unexp_write", 128'(ctx_w_v_o), 128'(0));
        else begin
          e = wq.pop_front();
          chk("write", 128'({ctx_w_kind_o, ctx_w_tid_o, ctx_w_addr_o, ctx_w_data_o}), 128'(e));
        end
      end
      if (ctx_r_v_o) begin
        if (rq.size() == 0) chk("unexp_read", 128'(ctx_r_v_o), 128'(0));
        else chk("read_tid", 128'(ctx_r_tid_o), 128'(rq.pop_front()));
      end
      if (redirect_v_o) begin
        if (dq.size() == 0) chk("unexp_redirect", 128'(redirect_v_o), 128'(0));
        else chk("redirect_npc", 128'(redirect_npc_o), 128'(dq.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"npc_t2", 1'b1, 2'd2, 39'h80001000, 1'b0, 2'd0, 5'd0, 64'd0, 1,
                mkw(1'b0, 2'd2, 5'd0, 64'h80001000), '0, 1'b0};
    vecs[1] = '{"rpush_t1", 1'b0, 2'd0, 39'd0, 1'b1, 2'd1, 5'd5, 64'h1234, 1,
                mkw(1'b1, 2'd1, 5'd5, 64'h1234), '0, 1'b0};
    vecs[2] = '{"npc_rp_t3", 1'b1, 2'd3, 39'h80003000, 1'b1, 2'd3, 5'd10, 64'hDEAD, 2,
                mkw(1'b0, 2'd3, 5'd0, 64'h80003000), mkw(1'b1, 2'd3, 5'd10, 64'hDEAD), 1'b0};
    vecs[3] = '{"npc_t1_rp_t2", 1'b1, 2'd1, 39'h7F_FFFF_FFFF, 1'b1, 2'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 2,
                mkw(1'b0, 2'd1, 5'd0, 64'h7F_FFFF_FFFF), mkw(1'b1, 2'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0};
    vecs[4] = '{"rpush_cur", 1'b0, 2'd0, 39'd0, 1'b1, 2'd0, 5'd3, 64'h55, 0, '0, '0, 1'b1};
    vecs[5] = '{"npc_cur", 1'b1, 2'd0, 39'h777, 1'b0, 2'd0, 5'd0, 64'd0, 0, '0, '0, 1'b1};

    reset_n_i    = 1'b0;
    clear_pulses();
    ctxt_tid_i   = '0;
    npc_tid_i    = '0;
    npc_i        = '0;
    rpush_tid_i  = '0;
    rpush_reg_i  = '0;
    rpush_data_i = '0;
    pipe_idle_i  = 1'b1;
    resume_npc_i = '0;
    ctx_r_npc_i  = '0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_stall", 128'(stall_o), 128'(0));
    chk("rst_wv", 128'(ctx_w_v_o), 128'(0));
    chk("rst_redir", 128'(redirect_v_o), 128'(0));
    chk("rst_cur", 128'(current_tid_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    tick();
    reset_n_i = 1'b1;
    tick();

    // NPC bootstrap: write lands the next cycle, busy for exactly that cycle.
    npc_v_i = 1'b1; npc_tid_i = 2'd2; npc_i = 39'h80001000;
    wq.push_back(mkw(1'b0, 2'd2, 5'd0, 64'h80001000));
    tick();
    clear_pulses();
    @(negedge clk_i);
    chk("npc_busy1", 128'(busy_o), 128'(1));
    chk("npc_wv1", 128'(ctx_w_v_o), 128'(1));
    tick();
    @(negedge clk_i);
    chk("npc_busy2", 128'(busy_o), 128'(0));
    tick();

    for (int i = 0; i < 6; i++) begin
      npc_v_i      = vecs[i].npc_v;
      npc_tid_i    = vecs[i].npc_tid;
      npc_i        = vecs[i].npc;
      rpush_v_i    = vecs[i].rp_v;
      rpush_tid_i  = vecs[i].rp_tid;
      rpush_reg_i  = vecs[i].rp_reg;
      rpush_data_i = vecs[i].rp_data;
      if (vecs[i].nw >= 1) wq.push_back(vecs[i].w0);
      if (vecs[i].nw >= 2) wq.push_back(vecs[i].w1);
      tick();
      clear_pulses();
      repeat (3) tick();
      @(negedge clk_i);
      chk({vecs[i].nm, "_err"}, 128'(err_o), 128'(vecs[i].exp_err));
      chk({vecs[i].nm, "_drained"}, 128'(wq.size()), 128'(0));
      tick();
    end

    do_reset();
    tick();

    // Switch 0 -> 1 with the backend already idle.
    ctxt_v_i = 1'b1; ctxt_tid_i = 2'd1; pipe_idle_i = 1'b1;
    resume_npc_i = 39'h80000040; ctx_r_npc_i = 39'h80002000;
    wq.push_back(mkw(1'b0, 2'd0, 5'd0, 64'h80000040));
    rq.push_back(2'd1);
    dq.push_back(39'h80002000);
    tick();
    clear_pulses();
    @(negedge clk_i);
    chk("sw1_drain_stall", 128'(stall_o), 128'(1));
    chk("sw1_drain_nowr", 128'(ctx_w_v_o), 128'(0));
    tick();
    @(negedge clk_i);
    chk("sw1_save_wv", 128'(ctx_w_v_o), 128'(1));
    tick();
    @(negedge clk_i);
    chk("sw1_load_rv", 128'(ctx_r_v_o), 128'(1));
    tick();
    @(negedge clk_i);
    chk("sw1_redir_v", 128'(redirect_v_o), 128'(1));
    chk("sw1_cur_old", 128'(current_tid_o), 128'(0));
    tick();
    @(negedge clk_i);
    chk("sw1_cur_new", 128'(current_tid_o), 128'(1));
    chk("sw1_stall_off", 128'(stall_o), 128'(0));
    chk("sw1_busy_off", 128'(busy_o), 128'(0));
    tick();

    // Switch 1 -> 2 with the backend busy for 6 cycles and an NPC for the target pending.
    ctxt_v_i = 1'b1; ctxt_tid_i = 2'd2; pipe_idle_i = 1'b0;
    npc_v_i = 1'b1; npc_tid_i = 2'd2; npc_i = 39'h80005000;
    resume_npc_i = 39'h80000080; ctx_r_npc_i = 39'h80006000;
    wq.push_back(mkw(1'b0, 2'd2, 5'd0, 64'h80005000));
    wq.push_back(mkw(1'b0, 2'd1, 5'd0, 64'h80000080));
    rq.push_back(2'd2);
    dq.push_back(39'h80006000);
    tick();
    clear_pulses();
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) pipe_idle_i = 1'b1;
      @(negedge clk_i);
      chk($sformatf("sw2_stall_c%0d", k), 128'(stall_o), 128'(1));
      chk($sformatf("sw2_wv_c%0d", k), 128'(ctx_w_v_o), 128'(k == 1));
      tick();
    end
    @(negedge clk_i);
    chk("sw2_save_wv", 128'(ctx_w_v_o), 128'(1));
    tick();
    @(negedge clk_i);
    chk("sw2_load_rv", 128'(ctx_r_v_o), 128'(1));
    tick();
    @(negedge clk_i);
    chk("sw2_redir_v", 128'(redirect_v_o), 128'(1));
    tick();
    @(negedge clk_i);
    chk("sw2_cur_new", 128'(current_tid_o), 128'(2));
    chk("sw2_stall_off", 128'(stall_o), 128'(0));
    tick();

    // Switch to the running thread: buffer drops after one cycle, nothing else happens.
    ctxt_v_i = 1'b1; ctxt_tid_i = 2'd2;
    tick();
    clear_pulses();
    @(negedge clk_i);
    chk("self_busy1", 128'(busy_o), 128'(1));
    chk("self_stall", 128'(stall_o), 128'(0));
    tick();
    @(negedge clk_i);
    chk("self_busy2", 128'(busy_o), 128'(0));
    chk("self_err", 128'(err_o), 128'(0));
    chk("self_cur", 128'(current_tid_o), 128'(2));
    tick();

    // Second NPC pulse while the first is still buffered is dropped.
    npc_v_i = 1'b1; npc_tid_i = 2'd3; npc_i = 39'h80007000;
    wq.push_back(mkw(1'b0, 2'd3, 5'd0, 64'h80007000));
    tick();
    npc_i = 39'h80007777;
    tick();
    clear_pulses();
    repeat (2) tick();
    @(negedge clk_i);
    chk("dbl_npc_err", 128'(err_o), 128'(1));
    chk("dbl_npc_drained", 128'(wq.size()), 128'(0));
    tick();

    // Reset asserted while in LOAD.
    ctxt_v_i = 1'b1; ctxt_tid_i = 2'd3; pipe_idle_i = 1'b1;
    resume_npc_i = 39'h800000C0; ctx_r_npc_i = 39'h80009000;
    wq.push_back(mkw(1'b0, 2'd2, 5'd0, 64'h800000C0));
    rq.push_back(2'd3);
    tick();
    clear_pulses();
    repeat (2) tick();
    @(negedge clk_i);
    chk("rstload_rv", 128'(ctx_r_v_o), 128'(1));
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("rstload_rv0", 128'(ctx_r_v_o), 128'(0));
    chk("rstload_stall0", 128'(stall_o), 128'(0));
    chk("rstload_busy0", 128'(busy_o), 128'(0));
    chk("rstload_cur0", 128'(current_tid_o), 128'(0));
    chk("rstload_err0", 128'(err_o), 128'(0));
    repeat (2) tick();
    reset_n_i = 1'b1;
    repeat (5) tick();
    @(negedge clk_i);
    chk("post_rst_cur", 128'(current_tid_o), 128'(0));
    chk("post_rst_stall", 128'(stall_o), 128'(0));

    chk("wq_empty", 128'(wq.size()), 128'(0));
    chk("rq_empty", 128'(rq.size()), 128'(0));
    chk("dq_empty", 128'(dq.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
